// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM generator.
//   - default parameter values (CH_NUM, CNT_W, PRESC_W)
//   - cnt_t counter type at default width
//   - pwm_mode_e counting mode
//   - pwm_cfg_t staging/active configuration record at default widths
// Optional feature macro: PWM_CENTER_ALIGN_EN (see pwm_multi_channel).
package pwm_pkg;

    localparam int CH_NUM_DEF  = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int PRESC_W_DEF = 8;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef struct packed {
        logic [PRESC_W_DEF-1:0]   prescale;
        cnt_t                     period;
        cnt_t [CH_NUM_DEF-1:0]    duty;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_multi_channel_prescaler.sv
// pwm_prescaler: clock divider shared by all PWM channels.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   enable      - low holds the divider at 0 and suppresses ticks
//   presc_act   - active divide value; tick every presc_act+1 clocks
//   tick        - combinational, high on the clock where the divider
//                 equals presc_act (divider wraps to 0 on that clock)
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PRESC_W-1:0] presc_act,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;

    always_comb begin
        tick = enable && (presc_cnt_q == presc_act);
        if (!enable || tick) begin
            presc_cnt_d = '0;
        end else begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: CH_NUM-channel PWM generator with a shared prescaler
// and period counter and per-channel duty compare. Prescale, period and
// duty are double-buffered: load stages them, and they become active only
// at a period boundary (or immediately while disabled).
// Ports:
//   clk, reset    - system clock, asynchronous active-high reset
//   enable        - run control; low holds counters at 0, q low
//   prescale      - counter advances every prescale+1 clocks
//   period        - edge mode period = period+1 ticks
//   duty          - packed duties, channel i = duty[i*CNT_W +: CNT_W]
//   load          - one-clock strobe capturing prescale/period/duty
//   center_mode   - only with PWM_CENTER_ALIGN_EN; sampled at boundaries
//   load_pending  - staged values waiting for a boundary
//   q             - registered PWM outputs
//   period_tick   - one-clock pulse, coincident with the counter reaching 0
// Optional feature macro: PWM_CENTER_ALIGN_EN (up/down counting).
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CH_NUM  = CH_NUM_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic [CH_NUM*CNT_W-1:0] duty,
    input  logic                    load,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                    center_mode,
`endif
    output logic                    load_pending,
    output logic [CH_NUM-1:0]       q,
    output logic                    period_tick
);

    typedef struct packed {
        logic [PRESC_W-1:0]      prescale;
        logic [CNT_W-1:0]        period;
        logic [CH_NUM*CNT_W-1:0] duty;
    } cfg_t;

    cfg_t               cfg_in;
    cfg_t               stage_q, stage_d;
    cfg_t               act_q, act_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               down_q, down_d;
    pwm_mode_e          mode_q, mode_d;
    logic [CH_NUM-1:0]  q_q, q_d;
    logic               ptick_q, ptick_d;
    logic               tick;
    logic               boundary;

    assign cfg_in = {prescale, period, duty};

    pwm_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .presc_act (act_q.prescale),
        .tick      (tick)
    );

    always_comb begin
        cnt_d    = cnt_q;
        down_d   = down_q;
        boundary = 1'b0;
        if (!enable) begin
            cnt_d  = '0;
            down_d = 1'b0;
        end else if (tick) begin
            if (mode_q == PWM_CENTER && act_q.period != '0) begin
                // Turn at the top without repeating period_act; the
                // boundary is the step that lands on 0 going down.
                if (!down_q && cnt_q < act_q.period) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    down_d = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d    = '0;
                        down_d   = 1'b0;
                        boundary = 1'b1;
                    end
                end
            end else begin
                if (cnt_q >= act_q.period) begin
                    cnt_d    = '0;
                    down_d   = 1'b0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

`ifdef PWM_CENTER_ALIGN_EN
        mode_d = boundary ? (center_mode ? PWM_CENTER : PWM_EDGE) : mode_q;
`else
        mode_d = PWM_EDGE;
`endif

        stage_d = stage_q;
        act_d   = act_q;
        pend_d  = pend_q;
        if (load) begin
            stage_d = cfg_in;
            pend_d  = 1'b1;
        end
        // A load coinciding with a boundary bypasses staging so the newest
        // inputs take effect on that same boundary.
        if (boundary && (load || pend_q)) begin
            act_d  = load ? cfg_in : stage_q;
            pend_d = 1'b0;
        end else if (!enable && pend_q && !load) begin
            act_d  = stage_q;
            pend_d = 1'b0;
        end

        ptick_d = boundary;
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        assign q_d[i] = enable && (cnt_q < act_q.duty[i*CNT_W +: CNT_W]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            act_q   <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            down_q  <= 1'b0;
            mode_q  <= PWM_EDGE;
            q_q     <= '0;
            ptick_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            down_q  <= down_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            ptick_q <= ptick_d;
        end
    end

    assign q            = q_q;
    assign period_tick  = ptick_q;
    assign load_pending = pend_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
module tb_pwm_multi_channel;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  prescale;
    logic [7:0]  period;
    logic [31:0] duty;
    logic        load;
`ifdef PWM_CENTER_ALIGN_EN
    logic        center_mode;
`endif
    logic        load_pending;
    logic [3:0]  q;
    logic        period_tick;

    pwm_multi_channel #(.CH_NUM(4), .CNT_W(8), .PRESC_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .prescale     (prescale),
        .period       (period),
        .duty         (duty),
        .load         (load),
`ifdef PWM_CENTER_ALIGN_EN
        .center_mode  (center_mode),
`endif
        .load_pending (load_pending),
        .q            (q),
        .period_tick  (period_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  presc;
        logic [7:0]  per;
        logic [31:0] dty;   // {ch3, ch2, ch1, ch0}
        int          span;
        int          h0, h1, h2, h3;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int span;
    int highs[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic do_load(input logic [7:0] p, input logic [7:0] per,
                           input logic [31:0] d);
        prescale = p;
        period   = per;
        duty     = d;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_ptick(input string name);
        int n = 0;
        while (!period_tick && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(period_tick), 1);
    endtask

    // Measures one full period starting at a period_tick sample: the
    // number of clocks to the next period_tick and per-channel high counts.
    task automatic measure(input string name);
        wait_ptick(name);
        span = 0;
        for (int i = 0; i < 4; i++) highs[i] = 0;
        do begin
            for (int i = 0; i < 4; i++) highs[i] += int'(q[i]);
            span++;
            @(negedge clk);
        end while (!period_tick && span < 2000);
    endtask

    vec_t vecs[5];

    initial begin
        int n, qsum, tsum;

        vecs[0] = '{8'd0, 8'd9,   {8'd5, 8'd10,  8'd0, 8'd3},   10,  3,   0,  10,   5};
        vecs[1] = '{8'd3, 8'd4,   {8'd4, 8'd5,   8'd0, 8'd2},   20,  8,   0,  20,  16};
        vecs[2] = '{8'd1, 8'd255, {8'd0, 8'd128, 8'd1, 8'd255}, 512, 510, 2,  256,  0};
        vecs[3] = '{8'd0, 8'd0,   {8'd0, 8'd255, 8'd1, 8'd0},   1,   0,   1,  1,    0};
        vecs[4] = '{8'd2, 8'd5,   {8'd0, 8'd1,   8'd5, 8'd6},   18,  18,  15, 3,    0};

        reset    = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        prescale = '0;
        period   = '0;
        duty     = '0;
`ifdef PWM_CENTER_ALIGN_EN
        center_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_q", int'(q), 0);
        check("reset_ptick", int'(period_tick), 0);
        check("reset_pending", int'(load_pending), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            enable = 1'b0;
            do_load(vecs[v].presc, vecs[v].per, vecs[v].dty);
            @(negedge clk);
            enable = 1'b1;
            measure($sformatf("v%0d_ptick", v));
            check($sformatf("v%0d_span", v), span, vecs[v].span);
            check($sformatf("v%0d_ch0_high", v), highs[0], vecs[v].h0);
            check($sformatf("v%0d_ch1_high", v), highs[1], vecs[v].h1);
            check($sformatf("v%0d_ch2_high", v), highs[2], vecs[v].h2);
            check($sformatf("v%0d_ch3_high", v), highs[3], vecs[v].h3);
        end

        // Mid-period duty reload: current period keeps duty 3, next uses 7.
        enable = 1'b0;
        do_load(8'd0, 8'd9, {8'd5, 8'd10, 8'd0, 8'd3});
        @(negedge clk);
        enable = 1'b1;
        wait_ptick("reload_ptick0");
        n = 0;
        qsum = 0;
        do begin
            qsum += int'(q[0]);
            n++;
            if (n == 4) begin
                duty[7:0] = 8'd7;
                load      = 1'b1;
            end
            if (n == 5) begin
                load = 1'b0;
                check("reload_pending_set", int'(load_pending), 1);
            end
            @(negedge clk);
        end while (!period_tick && n < 100);
        check("reload_pending_clr", int'(load_pending), 0);
        check("reload_old_high", qsum, 3);
        measure("reload_ptick1");
        check("reload_new_high", highs[0], 7);
        check("reload_span", span, 10);

        // Reset mid-period with a staged load.
        repeat (2) @(negedge clk);
        check("rst_pre_q0", int'(q[0]), 1);
        duty[7:0] = 8'd5;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("rst_pre_pending", int'(load_pending), 1);
        reset = 1'b1;
        #1;
        check("rst_async_q", int'(q), 0);
        check("rst_async_pending", int'(load_pending), 0);
        check("rst_async_ptick", int'(period_tick), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_after_q", int'(q), 0);
        check("rst_after_pending", int'(load_pending), 0);
        check("rst_after_ptick", int'(period_tick), 1);

        // Load coincident with a boundary (period_act=0 after reset).
        do_load(8'd0, 8'd9, {8'd5, 8'd10, 8'd0, 8'd3});
        check("same_clk_pending", int'(load_pending), 0);

        // Disable mid-period with a pending load, re-enable after 5 clocks.
        wait_ptick("dis_ptick0");
        repeat (3) @(negedge clk);
        do_load(8'd0, 8'd4, {8'd0, 8'd0, 8'd0, 8'd2});
        check("dis_pending_set", int'(load_pending), 1);
        enable = 1'b0;
        qsum = 0;
        tsum = 0;
        repeat (5) begin
            @(negedge clk);
            qsum += int'(q);
            tsum += int'(period_tick);
        end
        check("dis_q_low", qsum, 0);
        check("dis_ptick_low", tsum, 0);
        check("dis_pending_clr", int'(load_pending), 0);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 100);
        check("reen_first_period", n, 5);
        measure("reen_ptick");
        check("reen_span", span, 5);
        check("reen_ch0_high", highs[0], 2);

`ifdef PWM_CENTER_ALIGN_EN
        enable = 1'b0;
        center_mode = 1'b1;
        do_load(8'd0, 8'd4, {8'd0, 8'd0, 8'd0, 8'd2});
        @(negedge clk);
        enable = 1'b1;
        wait_ptick("ctr_ptick0");
        @(negedge clk);
        measure("ctr_ptick1");
        check("ctr_span", span, 8);
        check("ctr_q_at_boundary", int'(q[0]), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
